// File: rtl/store_buffer_if.sv
// Purpose: bundles the store, load-snoop and data_memory port signals of the
//          store buffer into one interface.
//   slave  : store buffer side (takes st_*/ld_* requests, drives memory port and status)
//   master : MEM stage / environment side
// Signals:
//   st_valid, st_addr, st_data, st_ready                 store enqueue handshake
//   ld_valid, ld_addr, ld_hit, ld_data, ld_stall         load snoop
//   mem_address, mem_write_data, mem_memorywrite,
//   mem_memoryread                                       data_memory port
//   empty, count                                         occupancy status
interface store_buffer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 64,
    parameter int unsigned DW    = 64
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;

    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          ld_stall;

    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_memorywrite;
    logic          mem_memoryread;

    logic          empty;
    logic [CW-1:0] count;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_hit, ld_data, ld_stall,
               mem_address, mem_write_data, mem_memorywrite, mem_memoryread,
               empty, count
    );

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_hit, ld_data, ld_stall,
               mem_address, mem_write_data, mem_memorywrite, mem_memoryread,
               empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Purpose: write-back store queue between the MEM stage and data_memory.
//          Stores enter a DEPTH-entry circular FIFO and drain one doubleword per
//          cycle whenever the memory port is not needed by a load. Loads snoop
//          the queued entries: an exact address match forwards the youngest data,
//          a partial (sub-doubleword) overlap stalls the load until it drains.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; discards all queued stores
//   sb     store_buffer_if.slave: store handshake, load snoop, memory port, status
// All sb outputs are combinational from the queue state and current inputs.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 64,
    parameter int unsigned DW    = 64
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  sb
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        entries_q [DEPTH];
    entry_t        entries_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          snoop_hit;
    logic          snoop_overlap;
    logic [DW-1:0] snoop_data;
    logic          ld_hit_c;
    logic          ld_stall_c;
    logic          mem_read_c;
    logic          enq_c;
    logic          deq_c;
    entry_t        head_c;

    // True when two byte addresses are within one doubleword of each other.
    function automatic logic addr_near(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW-1:0] d_ab;
        logic [AW-1:0] d_ba;
        d_ab = a - b;
        d_ba = b - a;
        return (d_ab < AW'(8)) || (d_ba < AW'(8));
    endfunction

    // Snoop valid entries oldest to youngest so the last exact match is the youngest.
    always_comb begin
        snoop_hit     = 1'b0;
        snoop_overlap = 1'b0;
        snoop_data    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (entries_q[PW'(rd_ptr_q + PW'(i))].addr == sb.ld_addr) begin
                    snoop_hit  = 1'b1;
                    snoop_data = entries_q[PW'(rd_ptr_q + PW'(i))].data;
                end else if (addr_near(entries_q[PW'(rd_ptr_q + PW'(i))].addr, sb.ld_addr)) begin
                    snoop_overlap = 1'b1;
                end
            end
        end
    end

    // Overlap wins over a hit elsewhere: forwarding would miss bytes from the overlapping store.
    assign ld_stall_c = sb.ld_valid & snoop_overlap;
    assign ld_hit_c   = sb.ld_valid & snoop_hit & ~snoop_overlap;
    assign mem_read_c = sb.ld_valid & ~ld_hit_c & ~ld_stall_c;

    // Full-queue acceptance uses the pre-edge count, so a drain does not free a slot this cycle.
    assign enq_c  = sb.st_valid & (count_q < CW'(DEPTH));
    assign deq_c  = (count_q != '0) & ~mem_read_c;
    assign head_c = entries_q[rd_ptr_q];

    // Next-state for pointers, occupancy and entry storage.
    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (enq_c) begin
            entries_d[wr_ptr_q] = '{addr: sb.st_addr, data: sb.st_data};
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (deq_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(enq_c) - CW'(deq_c);
    end

    // Control state; reset empties the queue immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payloads are only meaningful under count_q, so they need no reset.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign sb.st_ready        = count_q < CW'(DEPTH);
    assign sb.ld_hit          = ld_hit_c;
    assign sb.ld_stall        = ld_stall_c;
    assign sb.ld_data         = ld_hit_c ? snoop_data : '0;
    assign sb.mem_memoryread  = mem_read_c;
    assign sb.mem_memorywrite = deq_c;
    assign sb.mem_address     = deq_c ? head_c.addr : sb.ld_addr;
    assign sb.mem_write_data  = deq_c ? head_c.data : '0;
    assign sb.empty           = count_q == '0;
    assign sb.count           = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer with a byte-addressed data_memory model.
module tb_store_buffer;
    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:255];

    store_buffer_if #(.DEPTH(4), .AW(64), .DW(64)) sb ();

    store_buffer #(.DEPTH(4), .AW(64), .DW(64)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory captures a write at the clock edge, little-endian.
    always @(posedge clk) begin
        if (sb.mem_memorywrite) begin
            for (int k = 0; k < 8; k++) begin
                mem[8'(sb.mem_address[7:0] + 8'(k))] <= sb.mem_write_data[8*k +: 8];
            end
        end
    end

    function automatic logic [63:0] mem_rd(input logic [7:0] a, input int n);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++) begin
            v[8*k +: 8] = mem[8'(a + 8'(k))];
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                         input logic lv, input logic [63:0] la);
        sb.st_valid = sv;
        sb.st_addr  = sa;
        sb.st_data  = sd;
        sb.ld_valid = lv;
        sb.ld_addr  = la;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        sb.st_valid = 1'b0;
        sb.st_addr  = '0;
        sb.st_data  = '0;
        sb.ld_valid = 1'b0;
        sb.ld_addr  = '0;

        // Reset state
        #12;
        chk("rst_st_ready", sb.st_ready, 1);
        chk("rst_empty", sb.empty, 1);
        chk("rst_count", sb.count, 0);
        chk("rst_ld_hit", sb.ld_hit, 0);
        chk("rst_ld_stall", sb.ld_stall, 0);
        chk("rst_ld_data", sb.ld_data, 0);
        chk("rst_memwrite", sb.mem_memorywrite, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc();

        // 1: three stores drain on consecutive cycles in FIFO order
        drive(1, 64'h00, 64'h1, 0, 0);
        chk("t1_no_drain_when_empty", sb.mem_memorywrite, 0);
        cyc();
        drive(1, 64'h08, 64'h2, 0, 0);
        chk("t1_wr0", sb.mem_memorywrite, 1);
        chk("t1_addr0", sb.mem_address, 64'h00);
        chk("t1_data0", sb.mem_write_data, 64'h1);
        cyc();
        drive(1, 64'h10, 64'h3, 0, 0);
        chk("t1_wr1", sb.mem_memorywrite, 1);
        chk("t1_addr1", sb.mem_address, 64'h08);
        chk("t1_data1", sb.mem_write_data, 64'h2);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("t1_wr2", sb.mem_memorywrite, 1);
        chk("t1_addr2", sb.mem_address, 64'h10);
        chk("t1_data2", sb.mem_write_data, 64'h3);
        cyc();
        chk("t1_empty", sb.empty, 1);
        chk("t1_count", sb.count, 0);
        chk("t1_idle_wr", sb.mem_memorywrite, 0);
        chk("t1_mem08", mem_rd(8'h08, 8), 64'h2);

        // 2/5: fill under a missing load, hold a 5th store, full+drain rejects it
        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h40 + 64'(8 * i), 64'h11 + 64'(i), 1, 64'h30);
            chk("t2_fill_no_drain", sb.mem_memorywrite, 0);
            cyc();
        end
        drive(1, 64'h60, 64'h15, 1, 64'h30);
        chk("t2_full_count", sb.count, 4);
        chk("t2_full_not_ready", sb.st_ready, 0);
        chk("t2_memread", sb.mem_memoryread, 1);
        chk("t2_ld_addr_out", sb.mem_address, 64'h30);
        cyc();
        chk("t2_held_count", sb.count, 4);
        drive(1, 64'h60, 64'h15, 0, 0);
        chk("t5_full_drain_wr", sb.mem_memorywrite, 1);
        chk("t5_full_drain_addr", sb.mem_address, 64'h40);
        chk("t5_full_drain_data", sb.mem_write_data, 64'h11);
        chk("t5_full_drain_not_ready", sb.st_ready, 0);
        cyc();
        chk("t5_count_4to3", sb.count, 3);
        chk("t2_ready_after_drain", sb.st_ready, 1);
        chk("t2_drain_addr48", sb.mem_address, 64'h48);
        cyc();
        chk("t2_count_enq_deq", sb.count, 3);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_order_addr", sb.mem_address, 64'h50 + 64'(8 * i));
            chk("t2_order_data", sb.mem_write_data, 64'h13 + 64'(i));
            cyc();
        end
        chk("t2_empty", sb.empty, 1);

        // 3: youngest exact match forwarded
        drive(1, 64'h18, 64'h5, 1, 64'h70);
        cyc();
        drive(1, 64'h18, 64'h9, 1, 64'h70);
        chk("t3_miss_data0", sb.ld_data, 0);
        chk("t3_miss_hit0", sb.ld_hit, 0);
        cyc();
        drive(0, 0, 0, 1, 64'h18);
        chk("t3_hit", sb.ld_hit, 1);
        chk("t3_data_youngest", sb.ld_data, 64'h9);
        chk("t3_no_memread", sb.mem_memoryread, 0);
        chk("t3_no_stall", sb.ld_stall, 0);
        chk("t3_drain_on_hit", sb.mem_memorywrite, 1);
        cyc();
        chk("t3_hit_after_drain", sb.ld_data, 64'h9);
        drive(0, 0, 0, 0, 0);
        cyc();
        chk("t3_mem18", mem_rd(8'h18, 8), 64'h9);

        // 4: partial overlap stalls until drained, then load reads memory
        drive(1, 64'h20, 64'hAA, 1, 64'h70);
        cyc();
        drive(0, 0, 0, 1, 64'h1C);
        chk("t4_stall_below", sb.ld_stall, 1);
        drive(0, 0, 0, 1, 64'h28);
        chk("t4_no_stall_at_8", sb.ld_stall, 0);
        chk("t4_memread_at_8", sb.mem_memoryread, 1);
        drive(0, 0, 0, 1, 64'h24);
        chk("t4_stall", sb.ld_stall, 1);
        chk("t4_stall_no_hit", sb.ld_hit, 0);
        chk("t4_stall_no_memread", sb.mem_memoryread, 0);
        chk("t4_stall_drains", sb.mem_memorywrite, 1);
        cyc();
        chk("t4_stall_cleared", sb.ld_stall, 0);
        chk("t4_memread", sb.mem_memoryread, 1);
        chk("t4_memaddr", sb.mem_address, 64'h24);
        chk("t4_bytes24_27", mem_rd(8'h24, 4), 0);
        chk("t4_bytes20_23", mem_rd(8'h20, 4), 64'hAA);

        // 4b: stall takes priority over an exact hit on another entry
        drive(1, 64'h80, 64'h1, 1, 64'h70);
        cyc();
        drive(1, 64'h84, 64'h2, 1, 64'h70);
        cyc();
        drive(0, 0, 0, 1, 64'h80);
        chk("t4b_prio_stall", sb.ld_stall, 1);
        chk("t4b_prio_no_hit", sb.ld_hit, 0);
        chk("t4b_prio_data0", sb.ld_data, 0);
        cyc();
        chk("t4b_still_stall", sb.ld_stall, 1);
        cyc();
        chk("t4b_cleared", sb.ld_stall, 0);
        chk("t4b_memread", sb.mem_memoryread, 1);
        drive(0, 0, 0, 0, 0);

        // 5: ten stores back to back wrap the pointers, order preserved
        for (int i = 0; i < 10; i++) begin
            drive(1, 64'h90 + 64'(8 * i), 64'h100 + 64'(i), 0, 0);
            if (i > 0) begin
                chk("t5_wrap_addr", sb.mem_address, 64'h90 + 64'(8 * (i - 1)));
                chk("t5_wrap_data", sb.mem_write_data, 64'h100 + 64'(i - 1));
            end
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        chk("t5_wrap_last_addr", sb.mem_address, 64'hD8);
        chk("t5_wrap_last_data", sb.mem_write_data, 64'h109);
        cyc();
        chk("t5_wrap_empty", sb.empty, 1);
        chk("t5_wrap_memD8", mem_rd(8'hD8, 8), 64'h109);

        // 6: async reset mid-drain discards the queue at once
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'hE0 + 64'(8 * i), 64'h7 + 64'(i), 1, 64'h30);
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        chk("t6_pre_count", sb.count, 3);
        chk("t6_pre_wr", sb.mem_memorywrite, 1);
        reset = 1'b1;
        #1;
        chk("t6_count0", sb.count, 0);
        chk("t6_empty", sb.empty, 1);
        chk("t6_wr0", sb.mem_memorywrite, 0);
        chk("t6_ready", sb.st_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        chk("t6_post_empty", sb.empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
